serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full adder reused LSB-first
// over WIDTH cycles, with parallel result, carry-out and signed overflow.

module serial_addsub_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic             ser_sum,
    output logic             ser_valid,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    serial_addsub_fa u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last      = (cnt == CW'(WIDTH - 1));
    // busy is high exactly in RUN, so it doubles as the serial-bit qualifier
    assign ser_valid = busy;
    assign ser_sum   = busy & fa_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sh_a     <= '0;
            sh_b     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // subtract as a + ~b + ~borrow: invert b and the carry-in
                        sh_a  <= a;
                        sh_b  <= mode ? ~b : b;
                        carry <= cin ^ mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result <= {fa_s, result[WIDTH-1:1]};
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // carry still holds the carry into the MSB here
                        cout     <= fa_c;
                        overflow <= carry ^ fa_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=4: serial bits, results, flags,
// latency, ignored start in RUN, back-to-back start and mid-run reset.

module tb_serial_addsub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic         ser_sum;
    logic         ser_valid;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .ser_sum   (ser_sum),
        .ser_valid (ser_valid),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present operands with start for one edge, then scramble the inputs so
    // any late sampling shows up as a wrong result.
    task automatic drive_start(input logic m, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic c);
        start = 1'b1; mode = m; a = av; b = bv; cin = c;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; a = ~av; b = ~bv; cin = ~c;
    endtask

    // Called just after the start edge: checks WIDTH RUN cycles, then DONE.
    task automatic check_run(input string tag, input logic [W-1:0] er,
                             input logic ec, input logic eo);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_sval"}, {31'd0, ser_valid}, 32'd1);
            check({tag, "_ser"}, {31'd0, ser_sum}, {31'd0, er[i]});
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_idle"}, {30'd0, busy, ser_valid}, 32'd0);
        check({tag, "_res"}, {28'd0, result}, {28'd0, er});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic run_op(input string tag, input logic m, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic c, input logic [W-1:0] er,
                          input logic ec, input logic eo);
        @(negedge clk);
        drive_start(m, av, bv, c);
        check_run(tag, er, ec, eo);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {26'd0, result, cout, overflow}, {26'd0, er, ec, eo});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mode = 1'b0; a = 4'hf; b = 4'hf; cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {26'd0, done, ser_valid, result}, 32'd0);
        check("rst_flags", {30'd0, cout, overflow}, 32'd0);
        rst = 1'b0; start = 1'b0;

        run_op("add_a", 1'b0, 4'b1111, 4'b1100, 1'b0, 4'b1011, 1'b1, 1'b0);
        run_op("sub_a", 1'b1, 4'b1000, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b1);
        run_op("sub_b", 1'b1, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b0, 1'b0);
        run_op("add_b", 1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op("add_c", 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
        run_op("sub_c", 1'b1, 4'b0101, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0);
        run_op("sub_d", 1'b1, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0);

        // start during RUN must be ignored: 3+1 still finishes on time
        @(negedge clk);
        drive_start(1'b0, 4'b0011, 4'b0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 4'b1111; b = 4'b1111; cin = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ign_busy2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ign_busy3", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_res", {26'd0, result, cout, overflow}, {26'd0, 4'b0100, 2'b00});

        // back-to-back: start accepted in the DONE cycle
        @(negedge clk);
        drive_start(1'b0, 4'b0001, 4'b0010, 1'b0);
        check_run("b2b1", 4'b0011, 1'b0, 1'b0);
        drive_start(1'b0, 4'b0101, 4'b0110, 1'b0);
        check_run("b2b2", 4'b1011, 1'b0, 1'b1);

        // reset in the 2nd RUN cycle aborts; start right after is accepted
        @(negedge clk);
        drive_start(1'b0, 4'b1111, 4'b0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1; mode = 1'b1; a = 4'b0110; b = 4'b0011; cin = 1'b0;
        @(negedge clk);
        check("abort_busy", {30'd0, busy, done}, 32'd0);
        check("abort_outs", {25'd0, ser_valid, result, cout, overflow}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0; a = 4'b0000; b = 4'b0000;
        check_run("post_rst", 4'b0011, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
